vga_text_ctrl: RTL and testbench
================================

# vga_text_ctrl

Text-mode sequencer for the 8x16 VGA font ROM (`vga_font`). It maps incoming pixel coordinates to a character cell and reads the character code from an internal text buffer. It then drives the font ROM address fields and returns a pipelined, sync-aligned monochrome pixel stream with a blinking underline cursor. It sits between the VGA timing generator and the colour mux of the debug/overlay display path.

## Interface
- `COLS`, default 80: text columns (8 px each).
- `ROWS`, default 30: text rows (16 px each).
- `BLINK_FRAMES`, default 32: frames per cursor blink half-period.
- `clk`  in  1: pixel clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `x`, `y`  in  10 each: current pixel coordinates from the timing generator.
- `de_in`, `hs_in`, `vs_in`  in  1 each: display enable and syncs, aligned with `x`/`y`.
- `wr_en`  in  1: text buffer write strobe.
- `wr_addr`  in  12: cell index, computed as row*COLS+col.
- `wr_data`  in  7: ASCII code to store.
- `cursor_en`  in  1: cursor display enable.
- `cursor_addr`  in  12: cell index of the cursor.
- `font_ascii`  out  7: to `vga_font.ascii_code`.
- `font_row`  out  4: to `vga_font.row`.
- `font_col`  out  3: to `vga_font.col`.
- `font_pixel`  in  1: from `vga_font.pixel`. It is valid 1 cycle after the address fields.
- `de_out`, `hs_out`, `vs_out`  out  1 each: syncs delayed to match `pixel_out`.
- `pixel_out`  out  1: foreground pixel.
- `busy`  out  1: high while the buffer is being cleared.

## Operation
- FSM has 2 states, CLEAR and RUN.
  - Reset enters CLEAR with clear pointer `cp`=0.
  - In CLEAR, the FSM writes 0x20 to address `cp` each cycle and increments `cp`. After writing address COLS*ROWS-1 it moves to RUN.
  - In RUN it stays in RUN until the next reset.
- In CLEAR: `busy`=1, `wr_en` is ignored (the write is dropped, not queued), and `pixel_out` is forced to 0. Syncs still propagate.
- Text buffer is COLS*ROWS x 7 synchronous RAM.
  - A RUN-state write with `wr_addr` >= COLS*ROWS is ignored.
  - When a read and a write hit the same address in the same cycle, the read returns the old data (read-before-write).
- Cell mapping:
  - col = x>>3, row = y>>4.
  - index = row*COLS + col. The multiply uses 12-bit unsigned arithmetic. COLS*ROWS must be ≤ 4096.
  - font_row = y[3:0], font_col = x[2:0].
- In-area rule: x < COLS*8, y < ROWS*16, and de_in=1.
  - If the pixel is outside the area, or de is low, `pixel_out`=0 regardless of ROM or cursor.
- Cursor blink:
  - Frame counter increments on each rising edge of `vs_in`, detected with a registered previous `vs_in`.
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and toggles `blink`.
- Cursor pixel: if cursor_en, blink=1, cell index == cursor_addr, and font_row ∈ {14,15}, then `pixel_out`=1. This is an OR with `font_pixel`.
- `busy` falling does not reset the blink state.

## Timing
Pipeline, with T = cycle in which x/y/de/hs/vs are sampled:
- T+1: index, row and col registered. RAM address is applied, and the in-area flag and cursor-match flag are computed.
- T+2: RAM data is valid. `font_ascii` = RAM q; `font_row`/`font_col` are the T+1 values delayed one stage.
- T+3: `font_pixel` is valid.
- T+4: `pixel_out`, `de_out`, `hs_out` and `vs_out` are registered.

Total latency is 4 cycles, identical for pixel and syncs. Throughput is 1 pixel per cycle, with no stalls.

Reset values (async) are all 0: `pixel_out`, `de_out`, `hs_out`, `vs_out`, `font_ascii`, `font_row`, `font_col`, frame counter, `blink`, and `cp`. `busy` resets to 1.

Clear takes exactly COLS*ROWS cycles after rst deasserts. `busy` falls on the cycle after the last clear write.

Reset asserted mid-clear or mid-frame: outputs go to 0 immediately, the pipeline is flushed, and the clear restarts from `cp`=0.

A write in cycle W is visible to a read whose RAM address is applied at cycle W+1 or later.

## Test plan
- Reset release with COLS=80, ROWS=30 -> `busy`=1 for exactly 2400 cycles. Then reading every cell through the pixel path shows code 0x20: `font_ascii`=0x20 for all in-area pixels.
- Write 0x41 to cell 0, then scan (x=0..7, y=0..15) -> `font_ascii`=0x41 at T+2 with font_row=y[3:0] and font_col=x[2:0]. `pixel_out` equals the model ROM bit at T+4. `hs_out`/`vs_out` equal the inputs delayed 4 cycles.
- Pixel at x=640 or y=480 with a ROM model driving 1 -> `pixel_out`=0. With de_in=0 inside the area -> `pixel_out`=0.
- Write during CLEAR (wr_addr=5, 0x42) -> cell 5 still reads 0x20 after `busy` falls. A write to wr_addr=2400 leaves all cells unchanged.
- cursor_en=1, cursor_addr=81, BLINK_FRAMES=2, ROM model at 0, 4 vs pulses -> rows y=30,31 of cell (x=8..15) give `pixel_out`=1 only during frames with blink=1. The blink phase toggles every 2 frames; all other pixels are 0.
- Assert rst mid-frame during RUN -> all outputs are 0 in the same cycle. After release, `busy`=1 for another 2400 cycles, and previously written cells read 0x20.

Source files
------------

// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: text-mode sequencer for the 8x16 vga_font ROM.
// Maps pixel coordinates to a character cell, looks the code up in an
// internal text buffer, drives the font ROM address fields and returns a
// 4-cycle, sync-aligned monochrome pixel stream with a blinking underline
// cursor. After reset the buffer is filled with spaces before display starts.
module vga_text_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [6:0]  wr_data,
  input  logic        cursor_en,
  input  logic [11:0] cursor_addr,
  output logic [6:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [2:0]  font_col,
  input  logic        font_pixel,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        pixel_out,
  output logic        busy
);

  localparam int            CELLS      = COLS * ROWS;
  localparam logic [11:0]   LAST_CELL  = 12'(CELLS - 1);
  localparam logic [12:0]   CELL_LIMIT = 13'(CELLS);
  localparam logic [11:0]   COLS_W     = 12'(COLS);
  localparam logic [10:0]   X_LIMIT    = 11'(COLS * 8);
  localparam logic [10:0]   Y_LIMIT    = 11'(ROWS * 16);
  localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_next;
  logic [11:0] cp;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [6:0]  ram_wdata;
  logic [6:0]  mem [0:CELLS-1];

  logic          vs_prev;
  logic [FW-1:0] frame_cnt;
  logic          blink;

  logic [11:0] cell_idx;
  logic        in_area;

  logic [11:0] index_p1;
  logic [3:0]  row_p1;
  logic [2:0]  col_p1;
  logic        vld_p1, de_p1, hs_p1, vs_p1;
  logic        vld_p2, cursor_p2, de_p2, hs_p2, vs_p2;
  logic        vld_p3, cursor_p3, de_p3, hs_p3, vs_p3;

  // 12-bit cell index wraps exactly like the hardware multiplier would
  assign cell_idx = 12'(y[9:4]) * COLS_W + 12'(x[9:3]);
  assign in_area  = de_in && ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);

  // Clear/run state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Next state and buffer write port: clear owns the port, host writes are dropped meanwhile
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr;
    ram_wdata  = wr_data;
    case (state)
      CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = cp;
        ram_wdata = 7'h20;
        if (cp == LAST_CELL) state_next = RUN;
      end
      RUN: ram_we = wr_en && ({1'b0, wr_addr} < CELL_LIMIT);
      default: state_next = CLEAR;
    endcase
  end

  // Clear pointer walks every cell once per reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cp <= '0;
    else if (state == CLEAR) cp <= cp + 12'd1;
  end

  // Text buffer write port
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Frame counter on vs rising edges; blink toggles once per BLINK_FRAMES frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev   <= 1'b0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      if (vs_in && !vs_prev) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // ---- stage 1: cell index and glyph position; pixels sampled during clear are blanked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_p1 <= '0;
      row_p1   <= '0;
      col_p1   <= '0;
      vld_p1   <= 1'b0;
      de_p1    <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
    end else begin
      index_p1 <= cell_idx;
      row_p1   <= y[3:0];
      col_p1   <= x[2:0];
      vld_p1   <= in_area && (state == RUN);
      de_p1    <= de_in;
      hs_p1    <= hs_in;
      vs_p1    <= vs_in;
    end
  end

  // ---- stage 2: buffer read (old data on same-address write) and cursor match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      font_ascii <= '0;
      font_row   <= '0;
      font_col   <= '0;
      vld_p2     <= 1'b0;
      cursor_p2  <= 1'b0;
      de_p2      <= 1'b0;
      hs_p2      <= 1'b0;
      vs_p2      <= 1'b0;
    end else begin
      font_ascii <= mem[index_p1];
      font_row   <= row_p1;
      font_col   <= col_p1;
      vld_p2     <= vld_p1;
      cursor_p2  <= cursor_en && blink && (index_p1 == cursor_addr) && (row_p1[3:1] == 3'b111);
      de_p2      <= de_p1;
      hs_p2      <= hs_p1;
      vs_p2      <= vs_p1;
    end
  end

  // ---- stage 3: wait for the font ROM to answer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3    <= 1'b0;
      cursor_p3 <= 1'b0;
      de_p3     <= 1'b0;
      hs_p3     <= 1'b0;
      vs_p3     <= 1'b0;
    end else begin
      vld_p3    <= vld_p2;
      cursor_p3 <= cursor_p2;
      de_p3     <= de_p2;
      hs_p3     <= hs_p2;
      vs_p3     <= vs_p2;
    end
  end

  // ---- stage 4: merge glyph and cursor, register the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out <= 1'b0;
      de_out    <= 1'b0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
    end else begin
      pixel_out <= vld_p3 && (font_pixel || cursor_p3);
      de_out    <= de_p3;
      hs_out    <= hs_p3;
      vs_out    <= vs_p3;
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl: randomized pixel streams checked against a
// behavioural model (cell array, frame-edge count, ROM pattern function).
module tb_vga_text_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int BF    = 2;
  localparam int CELLS = COLS * ROWS;

  logic        clk;
  logic        rst;
  logic [9:0]  x, y;
  logic        de_in, hs_in, vs_in;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic        cursor_en;
  logic [11:0] cursor_addr;
  logic [6:0]  font_ascii;
  logic [3:0]  font_row;
  logic [2:0]  font_col;
  logic        font_pixel;
  logic        de_out, hs_out, vs_out, pixel_out, busy;

  vga_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr),
    .font_ascii(font_ascii), .font_row(font_row), .font_col(font_col),
    .font_pixel(font_pixel),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .pixel_out(pixel_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int rom_mode;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic rom_bit(input logic [6:0] a, input logic [3:0] r, input logic [2:0] c);
    if (rom_mode == 0) return 1'b0;
    if (rom_mode == 1) return 1'b1;
    return a[0] ^ a[3] ^ r[1] ^ c[0] ^ c[2] ^ (r[3] & c[1]);
  endfunction

  // Font ROM model: answers one cycle after the address fields
  always @(posedge clk) font_pixel <= rom_bit(font_ascii, font_row, font_col);

  logic [6:0] model_mem [CELLS];
  int         edges;
  logic       vs_last;
  logic [3:0]  q4[$];
  logic [14:0] q2[$];

  function automatic void model_reset();
    for (int i = 0; i < CELLS; i++) model_mem[i] = 7'h20;
    edges   = 0;
    vs_last = 1'b0;
    q4.delete();
    q2.delete();
  endfunction

  // One pixel cycle: returns matured expectations, records new ones, drives inputs
  task automatic step(input int sx, input int sy, input logic sde, input logic shs, input logic svs,
                      output logic m4, output logic [3:0] e4, output logic m2, output logic [14:0] e2);
    logic coords, cur, pix, blink_m;
    logic [6:0] asc;
    int idx;
    @(posedge clk); #1;
    m4 = (q4.size() == 4); e4 = '0;
    if (m4) e4 = q4.pop_front();
    m2 = (q2.size() == 2); e2 = '0;
    if (m2) e2 = q2.pop_front();
    if (svs && !vs_last) edges++;
    vs_last = svs;
    blink_m = ((edges / BF) % 2) == 1;
    coords  = (sx < COLS * 8) && (sy < ROWS * 16);
    idx     = (sy / 16) * COLS + (sx / 8);
    asc     = coords ? model_mem[idx] : 7'h00;
    cur     = cursor_en && blink_m && coords && (idx == int'(cursor_addr)) && ((sy % 16) >= 14);
    pix     = coords && sde && (rom_bit(asc, 4'(sy % 16), 3'(sx % 8)) || cur);
    q4.push_back({pix, sde, shs, svs});
    q2.push_back({coords, asc, 4'(sy % 16), 3'(sx % 8)});
    x = 10'(sx); y = 10'(sy); de_in = sde; hs_in = shs; vs_in = svs;
  endtask

  task automatic wr(input int a, input logic [6:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 12'(a); wr_data = d;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < CELLS) model_mem[a] = d;
    vs_last = 1'b0;
    q4.delete();
    q2.delete();
  endtask

  // Counts busy cycles after reset release and any non-zero pixel while clearing
  task automatic wait_clear(input logic try_wr, output int nbusy, output int npix);
    nbusy = 0; npix = 0;
    x = 10'd3; y = 10'd5; de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    for (int k = 0; k < 3000 && busy; k++) begin
      nbusy++;
      if (pixel_out !== 1'b0) npix++;
      wr_en = try_wr && (k < 2300); wr_addr = 12'd5; wr_data = 7'h42;
      @(posedge clk); #1;
    end
    wr_en = 1'b0; de_in = 1'b0;
  endtask

  task automatic test_reset();
    int nb, np;
    rst = 1'b1; x = 10'd9; y = 10'd17; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    rom_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({pixel_out, de_out, hs_out, vs_out} !== 4'b0) begin
      n_bad++; $display("FAIL reset_outs got=%b exp=0000", {pixel_out, de_out, hs_out, vs_out});
    end
    n_cmp++;
    if ({font_ascii, font_row, font_col} !== 14'h0) begin
      n_bad++; $display("FAIL reset_font got=%h exp=0", {font_ascii, font_row, font_col});
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy got=%b exp=1", busy);
    end
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    wait_clear(1'b0, nb, np);
    n_cmp++;
    if (nb != CELLS) begin
      n_bad++; $display("FAIL reset_clear_len got=%0d exp=%0d", nb, CELLS);
    end
    n_cmp++;
    if (np != 0) begin
      n_bad++; $display("FAIL reset_clear_pixel got=%0d exp=0", np);
    end
  endtask

  task automatic test_readback(input string tag);
    logic m4, m2; logic [3:0] e4; logic [14:0] e2;
    rom_mode = 2; cursor_en = 1'b0;
    for (int c = 0; c < CELLS + 4; c++) begin
      if (c < CELLS)
        step((c % COLS) * 8 + int'($urandom_range(7)), (c / COLS) * 16 + int'($urandom_range(15)),
             1'b1, 1'($urandom), 1'b0, m4, e4, m2, e2);
      else
        step(0, 0, 1'b0, 1'b0, 1'b0, m4, e4, m2, e2);
      if (m4) begin
        n_cmp++;
        if ({pixel_out, de_out, hs_out, vs_out} !== e4) begin
          n_bad++; $display("FAIL %s_out t=%0t got=%b exp=%b", tag, $time, {pixel_out, de_out, hs_out, vs_out}, e4);
        end
      end
      if (m2) begin
        n_cmp++;
        if ({e2[14] ? font_ascii : 7'h00, font_row, font_col} !== e2[13:0]) begin
          n_bad++; $display("FAIL %s_font t=%0t got=%h/%0d/%0d exp=%h/%0d/%0d", tag, $time,
                            font_ascii, font_row, font_col, e2[13:7], e2[6:3], e2[2:0]);
        end
      end
    end
  endtask

  task automatic test_cursor();
    logic m4, m2; logic [3:0] e4; logic [14:0] e2;
    int cnt;
    int exp_cnt [5] = '{0, 0, 16, 16, 0};
    rom_mode = 0; cursor_en = 1'b1; cursor_addr = 12'd81;
    for (int f = 0; f < 5; f++) begin
      cnt = 0;
      for (int k = 0; k < 6 * 24 + 6; k++) begin
        if (k < 144) step(k % 24, 28 + k / 24, 1'b1, 1'b0, 1'b0, m4, e4, m2, e2);
        else         step(0, 0, 1'b0, 1'b0, (k < 147), m4, e4, m2, e2);
        if (m4) begin
          if (pixel_out === 1'b1) cnt++;
          n_cmp++;
          if ({pixel_out, de_out, hs_out, vs_out} !== e4) begin
            n_bad++; $display("FAIL cursor_out t=%0t got=%b exp=%b", $time, {pixel_out, de_out, hs_out, vs_out}, e4);
          end
        end
      end
      n_cmp++;
      if (cnt != exp_cnt[f]) begin
        n_bad++; $display("FAIL cursor_frame%0d lit=%0d exp=%0d", f, cnt, exp_cnt[f]);
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_cell0();
    logic m4, m2; logic [3:0] e4; logic [14:0] e2;
    wr(0, 7'h41);
    rom_mode = 2; cursor_en = 1'b0;
    for (int k = 0; k < 128 + 4; k++) begin
      if (k < 128) step(k % 8, k / 8, 1'b1, 1'($urandom), 1'($urandom), m4, e4, m2, e2);
      else         step(0, 0, 1'b0, 1'b0, 1'b0, m4, e4, m2, e2);
      if (m4) begin
        n_cmp++;
        if ({pixel_out, de_out, hs_out, vs_out} !== e4) begin
          n_bad++; $display("FAIL cell0_out t=%0t got=%b exp=%b", $time, {pixel_out, de_out, hs_out, vs_out}, e4);
        end
      end
      if (m2) begin
        n_cmp++;
        if ({e2[14] ? font_ascii : 7'h00, font_row, font_col} !== e2[13:0]) begin
          n_bad++; $display("FAIL cell0_font t=%0t got=%h/%0d/%0d exp=%h/%0d/%0d", $time,
                            font_ascii, font_row, font_col, e2[13:7], e2[6:3], e2[2:0]);
        end
      end
    end
  endtask

  task automatic test_area_boundary();
    logic m4, m2; logic [3:0] e4; logic [14:0] e2;
    int   bx [8] = '{639, 640, 0, 0, 100, 1023, 639, 700};
    int   by [8] = '{0, 0, 479, 480, 100, 1023, 479, 10};
    logic bd [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rom_mode = 1; cursor_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) step(bx[k], by[k], bd[k], 1'b1, 1'b0, m4, e4, m2, e2);
      else       step(0, 0, 1'b0, 1'b0, 1'b0, m4, e4, m2, e2);
      if (m4) begin
        n_cmp++;
        if ({pixel_out, de_out, hs_out, vs_out} !== e4) begin
          n_bad++; $display("FAIL boundary_out t=%0t got=%b exp=%b", $time, {pixel_out, de_out, hs_out, vs_out}, e4);
        end
      end
    end
  endtask

  task automatic test_random();
    logic m4, m2; logic [3:0] e4; logic [14:0] e2;
    logic vsr;
    int cc, px, py;
    for (int i = 0; i < 40; i++) wr(int'($urandom_range(CELLS - 1)), 7'($urandom));
    wr(CELLS + int'($urandom_range(100)), 7'h7f);
    cc = int'($urandom_range(CELLS - 1));
    rom_mode = 2; cursor_en = 1'b1; cursor_addr = 12'(cc);
    vsr = 1'b0;
    for (int k = 0; k < 2004; k++) begin
      if ($urandom_range(39) == 0) vsr = ~vsr;
      if ($urandom_range(1) == 0) begin
        px = (cc % COLS) * 8 + int'($urandom_range(7));
        py = (cc / COLS) * 16 + int'($urandom_range(15));
      end else begin
        px = int'($urandom_range(719));
        py = int'($urandom_range(524));
      end
      if (k < 2000) step(px, py, ($urandom_range(7) != 0), 1'($urandom), vsr, m4, e4, m2, e2);
      else          step(0, 0, 1'b0, 1'b0, 1'b0, m4, e4, m2, e2);
      if (m4) begin
        n_cmp++;
        if ({pixel_out, de_out, hs_out, vs_out} !== e4) begin
          n_bad++; $display("FAIL random_out t=%0t got=%b exp=%b", $time, {pixel_out, de_out, hs_out, vs_out}, e4);
        end
      end
      if (m2) begin
        n_cmp++;
        if ({e2[14] ? font_ascii : 7'h00, font_row, font_col} !== e2[13:0]) begin
          n_bad++; $display("FAIL random_font t=%0t got=%h/%0d/%0d exp=%h/%0d/%0d", $time,
                            font_ascii, font_row, font_col, e2[13:7], e2[6:3], e2[2:0]);
        end
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_clear_write();
    int nb, np;
    @(posedge clk); #2 rst = 1'b1;
    model_reset();
    #10 rst = 1'b0;
    wait_clear(1'b1, nb, np);
    n_cmp++;
    if (nb != CELLS) begin
      n_bad++; $display("FAIL clrwr_clear_len got=%0d exp=%0d", nb, CELLS);
    end
    wr(CELLS, 7'h55);
    wr(4095, 7'h55);
    test_readback("clrwr");
  endtask

  task automatic test_reset_midframe();
    logic m4, m2; logic [3:0] e4; logic [14:0] e2;
    int nb, np;
    wr(100, 7'h33);
    wr(7, 7'h11);
    rom_mode = 1; cursor_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(9 + k, 17, 1'b1, 1'b1, 1'b1, m4, e4, m2, e2);
      if (m4) begin
        n_cmp++;
        if ({pixel_out, de_out, hs_out, vs_out} !== e4) begin
          n_bad++; $display("FAIL midrst_pre_out t=%0t got=%b exp=%b", $time, {pixel_out, de_out, hs_out, vs_out}, e4);
        end
      end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pixel_out, de_out, hs_out, vs_out} !== 4'b0) begin
      n_bad++; $display("FAIL midrst_outs got=%b exp=0000", {pixel_out, de_out, hs_out, vs_out});
    end
    n_cmp++;
    if ({font_ascii, font_row, font_col} !== 14'h0) begin
      n_bad++; $display("FAIL midrst_font got=%h exp=0", {font_ascii, font_row, font_col});
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL midrst_busy got=%b exp=1", busy);
    end
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    model_reset();
    #10 rst = 1'b0;
    wait_clear(1'b0, nb, np);
    n_cmp++;
    if (nb != CELLS) begin
      n_bad++; $display("FAIL midrst_clear_len got=%0d exp=%0d", nb, CELLS);
    end
    n_cmp++;
    if (np != 0) begin
      n_bad++; $display("FAIL midrst_clear_pixel got=%0d exp=0", np);
    end
    test_readback("midrst");
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cursor_en = 1'b0; cursor_addr = '0;
    rom_mode = 0;
    test_reset();
    test_readback("readback");
    test_cursor();
    test_cell0();
    test_area_boundary();
    test_random();
    test_clear_write();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t limit=2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
